beam_power_trigger: RTL and testbench



---
 rtl/beam_power_pkg.sv | 34 +++
 rtl/beam_power_trigger_if.sv | 32 +++
 rtl/beam_power_unit.sv | 127 ++++++++++++
 rtl/beam_power_trigger.sv | 59 +++++
 tb/tb_beam_power_trigger.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/beam_power_pkg.sv
// Shared widths, types and default delay table for the beam power trigger.
// Latency: none (declarations only).
// Backpressure: none.
package beam_power_pkg;

    localparam int NCHAN        = 8;
    localparam int NSAMP        = 8;
    localparam int SAMPLE_BITS  = 5;
    localparam int BEAM_BITS    = 9;
    localparam int SQUARE_BITS  = 15;
    localparam int POWER_BITS   = 18;
    localparam int DELAY_BITS   = 4;
    localparam int HIST_WORDS   = 3;
    localparam int WORD_BITS    = NSAMP * SAMPLE_BITS;
    localparam int BEAM_DLY_BITS = NCHAN * DELAY_BITS;

    localparam logic [POWER_BITS-1:0] THRESH_RESET   = 18'h3FFFF;
    localparam logic [63:0]           DEFAULT_DELAYS = 64'h76543210_00000000;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;
    typedef logic [WORD_BITS-1:0]          word_t;
    typedef word_t [NCHAN-1:0]             data_t;
    // Per channel: 24 samples, index 16+s is sample s of the newest word.
    typedef logic [NCHAN-1:0][HIST_WORDS*NSAMP-1:0][SAMPLE_BITS-1:0] hist_t;
    typedef logic signed [BEAM_BITS-1:0]   beam_t;
    typedef logic [SQUARE_BITS-1:0]        square_t;
    typedef logic [POWER_BITS-1:0]         power_t;

    // Delay in samples applied to channel c within one beam's delay word.
    function automatic int delay_of(input logic [BEAM_DLY_BITS-1:0] delays, input int c);
        return int'(delays[c*DELAY_BITS +: DELAY_BITS]);
    endfunction

endpackage

// File: rtl/beam_power_trigger_if.sv
// Sample/threshold/trigger bundle between the AGC chain and the trigger core.
// Latency: none (wiring only).
// Backpressure: none; the sample stream advances every clock.
interface beam_power_trigger_if
    import beam_power_pkg::*;
#(
    parameter int NBEAMS = 2
);

    data_t              data_i;
    power_t             thresh_i;
    logic [NBEAMS-1:0]  thresh_ce_i;
    logic               update_i;
    logic [NBEAMS-1:0]  trigger_o;

    modport master (
        output data_i,
        output thresh_i,
        output thresh_ce_i,
        output update_i,
        input  trigger_o
    );

    modport slave (
        input  data_i,
        input  thresh_i,
        input  thresh_ce_i,
        input  update_i,
        output trigger_o
    );

endinterface

// File: rtl/beam_power_unit.sv
// One delay-and-sum beam: delay select, channel sum, square, power sum, threshold compare.
// Latency: 4 registers after the shared history (sum, square, power, trigger).
// Backpressure: none; optional TRIGGER_HOLDOFF_EN masks the trigger after each firing.
module beam_power_unit
    import beam_power_pkg::*;
#(
    parameter logic [BEAM_DLY_BITS-1:0] DELAYS = '0,
    parameter int HOLDOFF_CLOCKS = 16
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  hist_t  hist,
    input  power_t thresh,
    input  logic   thresh_ce,
    input  logic   update,
    output logic   trigger
);

    beam_t   sum_d [NSAMP];
    beam_t   sum_q [NSAMP];
    square_t mag_d [NSAMP];
    square_t sq_d  [NSAMP];
    square_t sq_q  [NSAMP];
    power_t  power_d;
    power_t  power_q;
    power_t  pending_q;
    power_t  active_q;
    logic    raw_hit;

    // Which history samples are read depends on the delay set; the rest are dead.
    logic unused_hist;
    assign unused_hist = ^hist;

    // Delayed-sample sum across channels for each of the 8 output samples.
    always_comb begin
        for (int s = 0; s < NSAMP; s++) begin
            sum_d[s] = '0;
            for (int c = 0; c < NCHAN; c++) begin
                sum_d[s] = sum_d[s]
                         + beam_t'(sample_t'(hist[c][5'(2*NSAMP + s - delay_of(DELAYS, c))]));
            end
        end
    end

    // Square via magnitude so the product stays unsigned and 15 bits wide.
    always_comb begin
        for (int s = 0; s < NSAMP; s++) begin
            mag_d[s] = sum_q[s][BEAM_BITS-1] ? square_t'(-sum_q[s]) : square_t'(sum_q[s]);
            sq_d[s]  = mag_d[s] * mag_d[s];
        end
    end

    // Adder tree over the 8 squares; 8 * 16384 fits in 18 bits without saturation.
    always_comb begin
        power_d = '0;
        for (int s = 0; s < NSAMP; s++) begin
            power_d = power_d + power_t'(sq_q[s]);
        end
    end

    assign raw_hit = (power_q > active_q);

    // Sum, square and power pipeline registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NSAMP; s++) begin
                sum_q[s] <= '0;
                sq_q[s]  <= '0;
            end
            power_q <= '0;
        end else begin
            for (int s = 0; s < NSAMP; s++) begin
                sum_q[s] <= sum_d[s];
                sq_q[s]  <= sq_d[s];
            end
            power_q <= power_d;
        end
    end

    // Staged thresholds: an update copies the pending value from before this edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= THRESH_RESET;
            active_q  <= THRESH_RESET;
        end else begin
            if (thresh_ce) begin
                pending_q <= thresh;
            end
            if (update) begin
                active_q <= pending_q;
            end
        end
    end

`ifdef TRIGGER_HOLDOFF_EN
    localparam int HOLD_BITS = $clog2(HOLDOFF_CLOCKS + 1);
    logic [HOLD_BITS-1:0] hold_q;

    // Trigger with holdoff: after firing, force low for HOLDOFF_CLOCKS clocks, no restart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trigger <= 1'b0;
            hold_q  <= '0;
        end else if (hold_q != '0) begin
            trigger <= 1'b0;
            hold_q  <= hold_q - 1'b1;
        end else if (raw_hit) begin
            trigger <= 1'b1;
            hold_q  <= HOLD_BITS'(HOLDOFF_CLOCKS);
        end else begin
            trigger <= 1'b0;
        end
    end
`else
    localparam int unused_holdoff = HOLDOFF_CLOCKS;

    // Trigger is the plain registered strict compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trigger <= 1'b0;
        end else begin
            trigger <= raw_hit;
        end
    end
`endif

endmodule

// File: rtl/beam_power_trigger.sv
// Beamforming L1 trigger: shared 3-word sample history feeding NBEAMS power/threshold units.
// Latency: word sampled at edge k drives trigger_o after edge k+4.
// Backpressure: none; optional holdoff via TRIGGER_HOLDOFF_EN.
module beam_power_trigger
    import beam_power_pkg::*;
#(
    parameter int NBEAMS = 2,
    parameter logic [NBEAMS*32-1:0] BEAM_DELAYS = DEFAULT_DELAYS,
    parameter int HOLDOFF_CLOCKS = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    beam_power_trigger_if.slave bus
);

    data_t             cur_q;
    data_t             prev_q;
    data_t             prev2_q;
    hist_t             hist;
    logic [NBEAMS-1:0] trig;

    // History shift: newest word plus the two before it, cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q   <= '0;
            prev_q  <= '0;
            prev2_q <= '0;
        end else begin
            cur_q   <= bus.data_i;
            prev_q  <= cur_q;
            prev2_q <= prev_q;
        end
    end

    // Flatten each channel's three words into one oldest-first sample array.
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            hist[c] = {cur_q[c], prev_q[c], prev2_q[c]};
        end
    end

    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        beam_power_unit #(
            .DELAYS         (BEAM_DELAYS[b*BEAM_DLY_BITS +: BEAM_DLY_BITS]),
            .HOLDOFF_CLOCKS (HOLDOFF_CLOCKS)
        ) u_unit (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .hist      (hist),
            .thresh    (bus.thresh_i),
            .thresh_ce (bus.thresh_ce_i[b]),
            .update    (bus.update_i),
            .trigger   (trig[b])
        );
    end

    assign bus.trigger_o = trig;

endmodule

// File: tb/tb_beam_power_trigger.sv
// Randomized and directed bench for beam_power_trigger against a stream-level model.
// Latency: model predicts trigger from power of the word four edges earlier.
// Backpressure: none; one word per clock.
module tb_beam_power_trigger;
    import beam_power_pkg::*;

    localparam int NB   = 2;
    localparam int HOLD = 16;
    localparam logic [63:0] DLY = 64'h76543210_00000000;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    beam_power_trigger_if #(.NBEAMS(NB)) bus ();

    beam_power_trigger #(
        .NBEAMS         (NB),
        .BEAM_DELAYS    (DLY),
        .HOLDOFF_CLOCKS (HOLD)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: whole sample streams, per-word beam power, staged thresholds.
    logic [63:0] dly_tab;
    int xs [NCHAN][$];
    int pw [$];
    int pend [NB];
    int act  [NB];
    int hold [NB];
    int edge_n;

    function automatic int dly(input int b, input int c);
        return int'(dly_tab[(b*8+c)*4 +: 4]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCHAN; c++) xs[c].delete();
        pw.delete();
        for (int b = 0; b < NB; b++) begin
            pend[b] = 'h3FFFF;
            act[b]  = 'h3FFFF;
            hold[b] = 0;
        end
        edge_n = 0;
    endtask

    task automatic model_edge(input data_t d, input int th, input logic [NB-1:0] ce,
                              input logic up, output logic [NB-1:0] exp);
        sample_t smp;
        int p, y, idx, pv;
        logic raw;
        for (int c = 0; c < NCHAN; c++) begin
            for (int s = 0; s < NSAMP; s++) begin
                smp = d[c][5*s +: 5];
                xs[c].push_back(int'(smp));
            end
        end
        for (int b = 0; b < NB; b++) begin
            p = 0;
            for (int s = 0; s < NSAMP; s++) begin
                y = 0;
                for (int c = 0; c < NCHAN; c++) begin
                    idx = 8*edge_n + s - dly(b, c);
                    if (idx >= 0) y += xs[c][idx];
                end
                p += y*y;
            end
            pw.push_back(p);
        end
        for (int b = 0; b < NB; b++) begin
            pv  = (edge_n >= 4) ? pw[(edge_n-4)*NB + b] : 0;
            raw = (pv > act[b]);
`ifdef TRIGGER_HOLDOFF_EN
            if (hold[b] > 0) begin
                exp[b] = 1'b0;
                hold[b]--;
            end else begin
                exp[b] = raw;
                if (raw) hold[b] = HOLD;
            end
`else
            exp[b] = raw;
`endif
        end
        for (int b = 0; b < NB; b++) if (up) act[b] = pend[b];
        for (int b = 0; b < NB; b++) if (ce[b]) pend[b] = th;
        edge_n++;
    endtask

    // One clock: drive at negedge, model at posedge, sample and compare at next negedge.
    task automatic cycle(input data_t d, input int th, input logic [NB-1:0] ce,
                         input logic up, output logic [NB-1:0] got);
        logic [NB-1:0] exp;
        bus.data_i      = d;
        bus.thresh_i    = 18'(th);
        bus.thresh_ce_i = ce;
        bus.update_i    = up;
        @(posedge clk_i);
        model_edge(d, th, ce, up, exp);
        @(negedge clk_i);
        got = bus.trigger_o;
        check($sformatf("trig e%0d", edge_n-1), 32'(got), 32'(exp));
    endtask

    function automatic data_t const_word(input int v);
        data_t w;
        for (int c = 0; c < NCHAN; c++)
            for (int s = 0; s < NSAMP; s++)
                w[c][5*s +: 5] = 5'(v);
        return w;
    endfunction

    task automatic do_reset();
        rst_ni          = 1'b0;
        bus.data_i      = '0;
        bus.thresh_i    = '0;
        bus.thresh_ce_i = '0;
        bus.update_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset trig", 32'(bus.trigger_o), 32'd0);
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [NB-1:0] got;
        logic [NB-1:0] seen [7];
        data_t w;
        data_t z;
        data_t p1;
        data_t m16;

        dly_tab = DLY;
        z   = const_word(0);
        p1  = const_word(1);
        m16 = const_word(-16);
        bus.data_i      = '0;
        bus.thresh_i    = '0;
        bus.thresh_ce_i = '0;
        bus.update_i    = 1'b0;

        // Reset state and default thresholds under full-scale data.
        do_reset();
        repeat (8) cycle(m16, 0, 2'b00, 1'b0, got);
        check("t1 default thresh", 32'(got), 32'd0);

        // Staging without update has no effect; update brings beam0 live.
        cycle(p1, 100, 2'b01, 1'b0, got);
        repeat (6) cycle(p1, 0, 2'b00, 1'b0, got);
        check("t2 staged only", 32'(got), 32'd0);
        cycle(p1, 0, 2'b00, 1'b1, got);
        cycle(p1, 0, 2'b00, 1'b0, got);
        check("t2 after update", 32'(got), 32'd1);

        // Strict greater-than at P=512.
        cycle(p1, 511, 2'b01, 1'b0, got);
        cycle(p1, 0, 2'b00, 1'b1, got);
        cycle(p1, 0, 2'b00, 1'b0, got);
        check("t3 thresh 511", 32'(got), 32'd1);
        cycle(p1, 512, 2'b01, 1'b0, got);
        cycle(p1, 0, 2'b00, 1'b1, got);
        cycle(p1, 0, 2'b00, 1'b0, got);
        check("t3 thresh 512", 32'(got), 32'd0);

        // Single impulse on channel 7 sample 0: both beams P=225 in the same word.
        cycle(z, 224, 2'b11, 1'b0, got);
        cycle(z, 0, 2'b00, 1'b1, got);
        repeat (6) cycle(z, 0, 2'b00, 1'b0, got);
        w = z;
        w[7][4:0] = 5'd15;
        cycle(w, 0, 2'b00, 1'b0, seen[0]);
        for (int j = 1; j < 7; j++) cycle(z, 0, 2'b00, 1'b0, seen[j]);
        check("t4 k+3", 32'(seen[3]), 32'd0);
        check("t4 k+4", 32'(seen[4]), 32'd3);
        check("t4 k+5", 32'(seen[5]), 32'd0);

        // Full scale and simultaneous ce+update.
        cycle(m16, 131071, 2'b11, 1'b0, got);
        cycle(m16, 0, 2'b00, 1'b1, got);
        repeat (5) cycle(m16, 0, 2'b00, 1'b0, got);
        check("t5 full scale", 32'(got), 32'd3);
        cycle(m16, 131072, 2'b11, 1'b0, got);
        cycle(m16, 0, 2'b11, 1'b1, got);
        cycle(m16, 0, 2'b00, 1'b0, got);
        check("t5 ce+update old pending", 32'(got), 32'd0);
        cycle(m16, 0, 2'b00, 1'b1, got);
        cycle(m16, 0, 2'b00, 1'b0, got);
        check("t5 later update", 32'(got), 32'd3);

        // Asynchronous reset mid-operation clears the output without a clock edge.
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check("async reset", 32'(bus.trigger_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();

        // Randomized data and threshold traffic.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NCHAN; c++)
                for (int s = 0; s < NSAMP; s++)
                    w[c][5*s +: 5] = 5'($urandom_range(0, 31));
            cycle(w, int'($urandom_range(0, 12000)),
                  ($urandom_range(0, 5) == 0) ? NB'($urandom_range(1, 3)) : 2'b00,
                  ($urandom_range(0, 7) == 0), got);
        end

        // Constant stream with a low threshold (holdoff pattern when enabled).
        cycle(p1, 100, 2'b11, 1'b0, got);
        cycle(p1, 0, 2'b00, 1'b1, got);
        repeat (40) cycle(p1, 0, 2'b00, 1'b0, got);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
